// File: rtl/mux_scan_pipe_pkg.sv
// Shared constants and elaboration helpers for the scanning tree multiplexer.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Number of radix-4 levels needed to cover n inputs (ceil(log4 n)).
    function automatic int clog4(input int n);
        int r = 0;
        for (int v = 1; v < n; v = v * 4) begin
            r++;
        end
        return r;
    endfunction

    // Bits needed to name one of nch channels.
    function automatic int sel_width(input int nch);
        return $clog2(nch);
    endfunction

    // Registered tree levels between the channel bus and the output.
    function automatic int stage_count(input int nch);
        return clog4(nch);
    endfunction

endpackage

// File: rtl/mux_scan_pipe_if.sv
// Channel bus in, single tagged sample lane out.
interface mux_scan_pipe_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 16,
    parameter int SELW  = sel_width(NCH)
);

    logic [NCH*WIDTH-1:0] in_data;
    logic                 en;
    logic                 mode;
    logic [SELW-1:0]      sel_in;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic [SELW-1:0]      out_ch;
    logic                 scan_wrap;

    modport master (
        output in_data, en, mode, sel_in,
        input  out_data, out_valid, out_ch, scan_wrap
    );

    modport slave (
        input  in_data, en, mode, sel_in,
        output out_data, out_valid, out_ch, scan_wrap
    );

endinterface

// File: rtl/mux_scan_pipe_stage4.sv
// One registered 4:1 node of the mux tree; the tag rides along with the data.
module mux_stage4 #(
    parameter int WIDTH = 8,
    parameter int SELW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*WIDTH-1:0]   in_data,
    input  logic [1:0]           sel,
    input  logic                 valid_in,
    input  logic [SELW-1:0]      tag_in,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_tag
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  tag_q, tag_d;

    // Pick one of four inputs; data and tag only move on a valid sample so bubbles hold them.
    always_comb begin
        valid_d = valid_in;
        data_d  = data_q;
        tag_d   = tag_q;
        if (valid_in) begin
            data_d = in_data[32'(sel)*WIDTH +: WIDTH];
            tag_d  = tag_in;
        end
    end

    // Node registers, cleared asynchronously so in-flight samples are dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/mux_scan_pipe.sv
// Pipelined N:1 radix-4 tree mux with direct select and dwell-based auto-scan.
module mux_scan_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 16,
    parameter int DWELL = 4
) (
    input logic            clk,
    input logic            rst,
    mux_scan_pipe_if.slave bus
);

    localparam int SELW   = sel_width(NCH);
    localparam int STAGES = stage_count(NCH);

    logic [SELW-1:0] scan_ch_q, scan_ch_d;
    logic [7:0]      dwell_cnt_q, dwell_cnt_d;
    logic            scan_wrap_q, scan_wrap_d;
    logic            issue_valid;
    logic [SELW-1:0] issue_ch;

    // Channel issued this cycle: the direct index or the scan pointer.
    always_comb begin
        issue_valid = bus.en;
        issue_ch    = (bus.mode == MODE_SCAN) ? scan_ch_q : bus.sel_in;
    end

    // Scan pointer advances after DWELL accepts; direct mode parks the dwell count at zero.
    always_comb begin
        scan_ch_d   = scan_ch_q;
        dwell_cnt_d = dwell_cnt_q;
        scan_wrap_d = 1'b0;
        if (bus.en) begin
            if (bus.mode == MODE_SCAN) begin
                if (dwell_cnt_q == 8'(DWELL - 1)) begin
                    dwell_cnt_d = '0;
                    scan_ch_d   = scan_ch_q + 1'b1;
                    scan_wrap_d = (scan_ch_q == SELW'(NCH - 1));
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 8'd1;
                end
            end else begin
                dwell_cnt_d = '0;
            end
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ch_q   <= '0;
            dwell_cnt_q <= '0;
            scan_wrap_q <= 1'b0;
        end else begin
            scan_ch_q   <= scan_ch_d;
            dwell_cnt_q <= dwell_cnt_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    // Tree levels: stage k narrows NIN inputs to NIN/4 using tag bits [2k+1:2k].
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int NIN  = NCH >> (2 * k);
        localparam int NOUT = NIN / 4;

        logic [NIN*WIDTH-1:0]  din;
        logic [NIN-1:0]        vin;
        logic [NIN*SELW-1:0]   tin;
        logic [NOUT*WIDTH-1:0] dout;
        logic [NOUT-1:0]       vout;
        logic [NOUT*SELW-1:0]  tout;

        if (k == 0) begin : g_head
            assign din = bus.in_data;
            assign vin = {NIN{issue_valid}};
            assign tin = {NIN{issue_ch}};
        end else begin : g_link
            assign din = g_stage[k-1].dout;
            assign vin = g_stage[k-1].vout;
            assign tin = g_stage[k-1].tout;
        end

        for (genvar j = 0; j < NOUT; j++) begin : g_grp
            logic            grp_valid;
            logic [SELW-1:0] grp_tag;

            // The four siblings carry identical copies of valid and tag, so merging them is lossless.
            assign grp_valid = |vin[4*j +: 4];
            assign grp_tag   = tin[(4*j)*SELW   +: SELW] | tin[(4*j+1)*SELW +: SELW]
                             | tin[(4*j+2)*SELW +: SELW] | tin[(4*j+3)*SELW +: SELW];

            mux_stage4 #(
                .WIDTH (WIDTH),
                .SELW  (SELW)
            ) u_node (
                .clk       (clk),
                .rst       (rst),
                .in_data   (din[(4*j)*WIDTH +: 4*WIDTH]),
                .sel       (grp_tag[2*k +: 2]),
                .valid_in  (grp_valid),
                .tag_in    (grp_tag),
                .out_data  (dout[j*WIDTH +: WIDTH]),
                .out_valid (vout[j]),
                .out_tag   (tout[j*SELW +: SELW])
            );
        end
    end

    assign bus.out_data  = g_stage[STAGES-1].dout;
    assign bus.out_valid = g_stage[STAGES-1].vout[0];
    assign bus.out_ch    = g_stage[STAGES-1].tout;
    assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_scan_pipe.sv
// Scoreboard bench: two mux configurations driven in lockstep against a channel-level model.
module tb_mux_scan_pipe;

    localparam int A_W = 8,  A_N = 16, A_D = 4, A_S = 2, A_SELW = 4;
    localparam int B_W = 16, B_N = 64, B_D = 2, B_S = 3, B_SELW = 6;

    typedef struct {
        int          due;
        logic [63:0] data;
        int          ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Edge counter shared by driver and monitors.
    always @(posedge clk) cyc <= cyc + 1;

    mux_scan_pipe_if #(.WIDTH(A_W), .NCH(A_N)) a_bus ();
    mux_scan_pipe_if #(.WIDTH(B_W), .NCH(B_N)) b_bus ();

    mux_scan_pipe #(.WIDTH(A_W), .NCH(A_N), .DWELL(A_D)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_bus)
    );

    mux_scan_pipe #(.WIDTH(B_W), .NCH(B_N), .DWELL(B_D)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_bus)
    );

    exp_t        a_q[$], b_q[$];
    int          a_wq[$], b_wq[$];
    logic [7:0]  a_chan[A_N];
    logic [15:0] b_chan[B_N];
    int          a_scan = 0, a_dwell = 0, b_scan = 0, b_dwell = 0;
    logic [63:0] a_last_data = '0, b_last_data = '0;
    int          a_last_ch = 0, b_last_ch = 0;
    int          checks = 0, errors = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference scan behaviour: each channel owns DWELL consecutive scan accepts.
    task automatic model_step(input bit mode_i, input int sel, input int nch, input int dwell,
                              inout int scan, inout int dcnt, output int ch, output bit wrap);
        wrap = 1'b0;
        if (mode_i) begin
            ch = scan;
            dcnt++;
            if (dcnt == dwell) begin
                dcnt = 0;
                scan = (scan + 1) % nch;
                wrap = (scan == 0);
            end
        end else begin
            ch   = sel;
            dcnt = 0;
        end
    endtask

    task automatic apply_stimulus(input bit en_i, input bit mode_i, input int sel_a,
                                  input int sel_b, input bit rnd);
        int ch;
        bit wrap;
        @(negedge clk);
        if (rnd) begin
            for (int c = 0; c < A_N; c++) a_chan[c] = 8'($urandom);
            for (int c = 0; c < B_N; c++) b_chan[c] = 16'($urandom);
        end
        for (int c = 0; c < A_N; c++) a_bus.in_data[c*A_W +: A_W] = a_chan[c];
        for (int c = 0; c < B_N; c++) b_bus.in_data[c*B_W +: B_W] = b_chan[c];
        a_bus.en = en_i; a_bus.mode = mode_i; a_bus.sel_in = A_SELW'(sel_a);
        b_bus.en = en_i; b_bus.mode = mode_i; b_bus.sel_in = B_SELW'(sel_b);
        if (en_i) begin
            model_step(mode_i, sel_a, A_N, A_D, a_scan, a_dwell, ch, wrap);
            a_q.push_back('{cyc + A_S, 64'(a_chan[ch]), ch});
            if (wrap) a_wq.push_back(cyc + 1);
            model_step(mode_i, sel_b, B_N, B_D, b_scan, b_dwell, ch, wrap);
            b_q.push_back('{cyc + B_S, 64'(b_chan[ch]), ch});
            if (wrap) b_wq.push_back(cyc + 1);
        end
    endtask

    // Monitor for the 16-channel instance.
    initial begin : mon_a
        exp_t e;
        bit   exp_v, exp_w;
        forever begin
            @(posedge clk);
            #1;
            exp_v = (a_q.size() > 0 && a_q[0].due == cyc);
            check_output("a_valid", 64'(a_bus.out_valid), 64'(exp_v));
            if (exp_v) begin
                e = a_q.pop_front();
                check_output("a_data", 64'(a_bus.out_data), e.data);
                check_output("a_ch", 64'(a_bus.out_ch), 64'(e.ch));
                a_last_data = e.data;
                a_last_ch   = e.ch;
            end else begin
                check_output("a_hold_data", 64'(a_bus.out_data), a_last_data);
                check_output("a_hold_ch", 64'(a_bus.out_ch), 64'(a_last_ch));
            end
            exp_w = (a_wq.size() > 0 && a_wq[0] == cyc);
            if (exp_w) void'(a_wq.pop_front());
            check_output("a_wrap", 64'(a_bus.scan_wrap), 64'(exp_w));
        end
    end

    // Monitor for the 64-channel instance.
    initial begin : mon_b
        exp_t e;
        bit   exp_v, exp_w;
        forever begin
            @(posedge clk);
            #1;
            exp_v = (b_q.size() > 0 && b_q[0].due == cyc);
            check_output("b_valid", 64'(b_bus.out_valid), 64'(exp_v));
            if (exp_v) begin
                e = b_q.pop_front();
                check_output("b_data", 64'(b_bus.out_data), e.data);
                check_output("b_ch", 64'(b_bus.out_ch), 64'(e.ch));
                b_last_data = e.data;
                b_last_ch   = e.ch;
            end else begin
                check_output("b_hold_data", 64'(b_bus.out_data), b_last_data);
                check_output("b_hold_ch", 64'(b_bus.out_ch), 64'(b_last_ch));
            end
            exp_w = (b_wq.size() > 0 && b_wq[0] == cyc);
            if (exp_w) void'(b_wq.pop_front());
            check_output("b_wrap", 64'(b_bus.scan_wrap), 64'(exp_w));
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        a_bus.in_data = '0; a_bus.en = 1'b0; a_bus.mode = 1'b0; a_bus.sel_in = '0;
        b_bus.in_data = '0; b_bus.en = 1'b0; b_bus.mode = 1'b0; b_bus.sel_in = '0;
        for (int c = 0; c < A_N; c++) a_chan[c] = 8'h10 + 8'(c);
        for (int c = 0; c < B_N; c++) b_chan[c] = 16'($urandom);
        b_chan[63] = 16'hBEEF;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Direct select of fixed channel patterns.
        apply_stimulus(1, 0, 5, 63, 0);
        apply_stimulus(1, 0, 13, 63, 0);
        repeat (4) apply_stimulus(0, 0, 0, 0, 0);

        // Bubble pattern 1,0,1.
        apply_stimulus(1, 0, 3, 17, 1);
        apply_stimulus(0, 0, 7, 40, 1);
        apply_stimulus(1, 0, 11, 2, 1);
        repeat (4) apply_stimulus(0, 0, 0, 0, 1);

        // Full scan sweep on the 16-channel instance.
        repeat (64) apply_stimulus(1, 1, 0, 0, 1);
        repeat (4) apply_stimulus(0, 1, 0, 0, 1);

        // Asynchronous reset with samples still in the pipe.
        apply_stimulus(1, 0, 9, 50, 1);
        apply_stimulus(1, 0, 4, 21, 1);
        apply_stimulus(0, 0, 0, 0, 1);
        #2 rst = 1'b1;
        #1;
        check_output("rst_a_data", 64'(a_bus.out_data), 64'd0);
        check_output("rst_a_valid", 64'(a_bus.out_valid), 64'd0);
        check_output("rst_a_ch", 64'(a_bus.out_ch), 64'd0);
        check_output("rst_a_wrap", 64'(a_bus.scan_wrap), 64'd0);
        check_output("rst_b_data", 64'(b_bus.out_data), 64'd0);
        check_output("rst_b_valid", 64'(b_bus.out_valid), 64'd0);
        check_output("rst_b_ch", 64'(b_bus.out_ch), 64'd0);
        check_output("rst_b_wrap", 64'(b_bus.scan_wrap), 64'd0);
        a_q.delete(); b_q.delete(); a_wq.delete(); b_wq.delete();
        a_scan = 0; a_dwell = 0; b_scan = 0; b_dwell = 0;
        a_last_data = '0; a_last_ch = 0; b_last_data = '0; b_last_ch = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) apply_stimulus(0, 1, 0, 0, 1);

        // Scan, detour through direct channel 9, then resume scanning.
        repeat (3) apply_stimulus(1, 1, 0, 0, 1);
        repeat (3) apply_stimulus(1, 0, 9, 9, 1);
        repeat (4) apply_stimulus(1, 1, 0, 0, 1);
        repeat (4) apply_stimulus(0, 1, 0, 0, 1);

        // Random traffic.
        repeat (400) begin
            apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, A_N - 1)), int'($urandom_range(0, B_N - 1)), 1);
        end
        repeat (8) apply_stimulus(0, 0, 0, 0, 1);

        check_output("a_drain", 64'(a_q.size()), 64'd0);
        check_output("b_drain", 64'(b_q.size()), 64'd0);
        check_output("a_wrap_drain", 64'(a_wq.size()), 64'd0);
        check_output("b_wrap_drain", 64'(b_wq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
